// File: rtl/spi_packet_master_pkg.sv
// Shared definitions for the SPI packet link: byte width and master FSM state codes.
package spi_pkg;

  localparam int unsigned BYTE_SIZE = 8;

  // State codes are plain constants so older code can compare against raw values.
  typedef logic [2:0] spi_master_state_t;

  localparam spi_master_state_t IDLE  = 3'd0;
  localparam spi_master_state_t SETUP = 3'd1;
  localparam spi_master_state_t XFER  = 3'd2;
  localparam spi_master_state_t HOLD  = 3'd3;
  localparam spi_master_state_t GAP   = 3'd4;

endpackage

// File: rtl/spi_packet_master_if.sv
// Host-side handshake plus the SPI pins of the packet master, bundled as one port.
interface spi_packet_master_if
  import spi_pkg::*;
#(
  parameter int unsigned PACKET_SIZE = 8
);

  logic                              startIn;
  logic [PACKET_SIZE*BYTE_SIZE-1:0]  dataIn;
  logic [PACKET_SIZE*BYTE_SIZE-1:0]  dataOut;
  logic                              busyOut;
  logic                              doneOut;
  logic                              ssOut;
  logic                              sckOut;
  logic                              mosiOut;
  logic                              misoIn;

  // View of the SPI master itself.
  modport master (
    input  startIn, dataIn, misoIn,
    output dataOut, busyOut, doneOut, ssOut, sckOut, mosiOut
  );

  // View of whatever drives the master (host logic and the slave model).
  modport slave (
    output startIn, dataIn, misoIn,
    input  dataOut, busyOut, doneOut, ssOut, sckOut, mosiOut
  );

endinterface

// File: rtl/spi_sck_gen.sv
// SCK phase/bit sequencer: strobes for the rising and falling SCK edges of each bit.
module spi_sck_gen #(
  parameter int unsigned HALF_PERIOD = 8,
  parameter int unsigned NUM_BITS    = 64
) (
  input  logic clk,
  input  logic nResetIn,
  input  logic enable,
  output logic riseStb,
  output logic fallStb,
  output logic lastBit
);

  localparam int unsigned PhW  = $clog2(2 * HALF_PERIOD);
  localparam int unsigned BitW = $clog2(NUM_BITS + 1);

  localparam logic [PhW-1:0]  PhRise  = PhW'(HALF_PERIOD - 1);
  localparam logic [PhW-1:0]  PhLast  = PhW'(2 * HALF_PERIOD - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(NUM_BITS - 1);

  logic [PhW-1:0]  phase;
  logic [BitW-1:0] bitCnt;

  // Strobes fire on the last clk of the low phase (rise) and of the high phase (fall).
  assign riseStb = enable && (phase == PhRise);
  assign fallStb = enable && (phase == PhLast);
  assign lastBit = (bitCnt == BitLast);

  // Phase walks 0..2*HALF_PERIOD-1 per bit; both counters park at zero when idle.
  always_ff @(posedge clk or negedge nResetIn) begin
    if (!nResetIn) begin
      phase  <= '0;
      bitCnt <= '0;
    end else if (!enable) begin
      phase  <= '0;
      bitCnt <= '0;
    end else if (phase == PhLast) begin
      phase  <= '0;
      bitCnt <= bitCnt + 1'b1;
    end else begin
      phase  <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/spi_packet_master.sv
// Mode-0 full-duplex SPI master moving one PACKET_SIZE-byte packet per SS frame.
module spi_packet_master
  import spi_pkg::*;
#(
  parameter int unsigned PACKET_SIZE = 8,
  parameter int unsigned HALF_PERIOD = 8,
  parameter int unsigned SS_SETUP    = 4,
  parameter int unsigned SS_HOLD     = 4,
  parameter int unsigned SS_GAP      = 8
) (
  input  logic                 clk,
  input  logic                 nResetIn,
  spi_packet_master_if.master  bus
);

  localparam int unsigned NumBits = PACKET_SIZE * BYTE_SIZE;
  localparam int unsigned MaxDur  = (SS_SETUP > SS_HOLD)
                                    ? ((SS_SETUP > SS_GAP) ? SS_SETUP : SS_GAP)
                                    : ((SS_HOLD > SS_GAP) ? SS_HOLD : SS_GAP);
  localparam int unsigned TmrW    = $clog2(MaxDur + 1);

  localparam logic [TmrW-1:0] SetupLast = TmrW'(SS_SETUP - 1);
  localparam logic [TmrW-1:0] HoldLast  = TmrW'(SS_HOLD - 1);
  localparam logic [TmrW-1:0] GapLast   = TmrW'(SS_GAP - 1);

  spi_master_state_t    state, stateNext;
  logic [TmrW-1:0]      tmr, tmrNext;
  logic [NumBits-1:0]   txReg, txNext;
  logic [NumBits-1:0]   rxReg, rxNext;
  logic [NumBits-1:0]   dataNext;
  logic                 doneNext;
  logic                 sckNext;
  logic                 inFrame;
  logic                 riseStb, fallStb, lastBit;

  spi_sck_gen #(
    .HALF_PERIOD (HALF_PERIOD),
    .NUM_BITS    (NumBits)
  ) u_sck_gen (
    .clk      (clk),
    .nResetIn (nResetIn),
    .enable   (state == XFER),
    .riseStb  (riseStb),
    .fallStb  (fallStb),
    .lastBit  (lastBit)
  );

  // Next-state, timer and shift-register update for the frame sequence.
  always_comb begin
    stateNext = state;
    tmrNext   = tmr + 1'b1;
    txNext    = txReg;
    rxNext    = rxReg;
    doneNext  = 1'b0;
    dataNext  = bus.dataOut;
    case (state)
      IDLE: begin
        tmrNext = '0;
        if (bus.startIn) begin
          txNext    = bus.dataIn;
          stateNext = SETUP;
        end
      end
      SETUP: begin
        if (tmr == SetupLast) begin
          tmrNext   = '0;
          stateNext = XFER;
        end
      end
      XFER: begin
        tmrNext = '0;
        // Sample MISO as late as possible: the clk before SCK drops.
        if (fallStb) begin
          txNext = {txReg[NumBits-2:0], 1'b0};
          rxNext = {rxReg[NumBits-2:0], bus.misoIn};
          if (lastBit) begin
            stateNext = HOLD;
          end
        end
      end
      HOLD: begin
        if (tmr == HoldLast) begin
          tmrNext   = '0;
          stateNext = GAP;
          doneNext  = 1'b1;
          dataNext  = rxReg;
        end
      end
      GAP: begin
        if (tmr == GapLast) begin
          tmrNext   = '0;
          stateNext = IDLE;
        end
      end
      default: begin
        tmrNext   = '0;
        stateNext = IDLE;
      end
    endcase
  end

  // Pin values are derived from the next state so every output comes straight from a flop.
  assign inFrame = (stateNext == SETUP) || (stateNext == XFER) || (stateNext == HOLD);
  assign sckNext = (stateNext == XFER) && (riseStb || (bus.sckOut && !fallStb));

  // State, shift registers and registered outputs.
  always_ff @(posedge clk or negedge nResetIn) begin
    if (!nResetIn) begin
      state       <= IDLE;
      tmr         <= '0;
      txReg       <= '0;
      rxReg       <= '0;
      bus.ssOut   <= 1'b1;
      bus.sckOut  <= 1'b0;
      bus.mosiOut <= 1'b0;
      bus.busyOut <= 1'b0;
      bus.doneOut <= 1'b0;
      bus.dataOut <= '0;
    end else begin
      state       <= stateNext;
      tmr         <= tmrNext;
      txReg       <= txNext;
      rxReg       <= rxNext;
      bus.ssOut   <= !inFrame;
      bus.sckOut  <= sckNext;
      bus.mosiOut <= inFrame && txNext[NumBits-1];
      bus.busyOut <= (stateNext != IDLE);
      bus.doneOut <= doneNext;
      bus.dataOut <= dataNext;
    end
  end

endmodule

// File: tb/tb_spi_packet_master.sv
// Bench for spi_packet_master: default-parameter instance plus a minimal corner instance.
module tb_spi_packet_master;

  typedef struct {
    int          doneCyc;
    int          ssFallCyc;
    logic [63:0] rx;
    logic [63:0] tx;
  } exp_t;

  typedef struct {
    logic [63:0] tx;
    logic [63:0] miso;
    int          dly;
    int          doneLat;
    int          idleLat;
  } vec_t;

  logic clk = 1'b0;
  logic nResetIn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  spi_packet_master_if #(.PACKET_SIZE(8)) bus0 ();
  spi_packet_master_if #(.PACKET_SIZE(1)) bus1 ();

  spi_packet_master #(
    .PACKET_SIZE (8),
    .HALF_PERIOD (8),
    .SS_SETUP    (4),
    .SS_HOLD     (4),
    .SS_GAP      (8)
  ) dut0 (
    .clk      (clk),
    .nResetIn (nResetIn),
    .bus      (bus0)
  );

  spi_packet_master #(
    .PACKET_SIZE (1),
    .HALF_PERIOD (2),
    .SS_SETUP    (1),
    .SS_HOLD     (1),
    .SS_GAP      (1)
  ) dut1 (
    .clk      (clk),
    .nResetIn (nResetIn),
    .bus      (bus1)
  );

  exp_t q0[$];
  exp_t q1[$];

  // Slave model and monitor state, default instance.
  logic [63:0] sr0 = '0, pat0 = '0, mosiCap0 = '0;
  int          dly0 = 0, pend0 = 0, rises0 = 0;
  int          ssFall0 = -1, ssRise0 = -1, busyFall0 = -1;
  logic        pSs0 = 1'b1, pSck0 = 1'b0, pBusy0 = 1'b0;

  // Slave model and monitor state, corner instance.
  logic [7:0]  sr1 = '0, pat1 = '0, mosiCap1 = '0;
  int          rises1 = 0, ssFall1 = -1, busyFall1 = -1;
  logic        pSs1 = 1'b1, pSck1 = 1'b0, pBusy1 = 1'b0;

  assign bus0.misoIn = sr0[63];
  assign bus1.misoIn = sr1[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkTrue(input string name, input bit cond, input int act);
    checks++;
    if (!cond) begin
      failures++;
      $display("FAIL %s: got %0d, outside required range (cycle %0d)", name, act, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Default instance: mode-0 slave (optionally late MISO) plus scoreboard consumer.
  initial forever begin
    bit doShift;
    exp_t e;
    @(negedge clk);
    if (pSs0 && !bus0.ssOut) begin
      sr0     = pat0;
      pend0   = 0;
      rises0  = 0;
      ssFall0 = cyc;
      if (ssRise0 >= 0) checkTrue("ss_gap", (cyc - ssRise0) >= 8, cyc - ssRise0);
    end else begin
      doShift = (pSck0 && !bus0.sckOut && dly0 == 0) || (pend0 == 1);
      if (pend0 > 0) pend0--;
      if (pSck0 && !bus0.sckOut && dly0 > 0) pend0 = dly0;
      if (doShift) sr0 = sr0 << 1;
    end
    if (!pSs0 && bus0.ssOut) ssRise0 = cyc;
    if (!pSck0 && bus0.sckOut) begin
      rises0++;
      mosiCap0 = {mosiCap0[62:0], bus0.mosiOut};
    end
    if (pBusy0 && !bus0.busyOut) busyFall0 = cyc;
    if (bus0.doneOut) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done0: got done at cycle %0d, required none", cyc);
      end else begin
        e = q0.pop_front();
        check("done_cycle", cyc, e.doneCyc);
        check("ss_fall_cycle", ssFall0, e.ssFallCyc);
        check("rx_data", bus0.dataOut, e.rx);
        check("mosi_stream", mosiCap0, e.tx);
        check("sck_rises", rises0, 64);
      end
    end
    pSs0   = bus0.ssOut;
    pSck0  = bus0.sckOut;
    pBusy0 = bus0.busyOut;
  end

  // Corner instance: zero-delay mode-0 slave plus scoreboard consumer.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (pSs1 && !bus1.ssOut) begin
      sr1     = pat1;
      rises1  = 0;
      ssFall1 = cyc;
    end else if (pSck1 && !bus1.sckOut) begin
      sr1 = sr1 << 1;
    end
    if (!pSck1 && bus1.sckOut) begin
      rises1++;
      mosiCap1 = {mosiCap1[6:0], bus1.mosiOut};
    end
    if (pBusy1 && !bus1.busyOut) busyFall1 = cyc;
    if (bus1.doneOut) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done1: got done at cycle %0d, required none", cyc);
      end else begin
        e = q1.pop_front();
        check("c_done_cycle", cyc, e.doneCyc);
        check("c_ss_fall_cycle", ssFall1, e.ssFallCyc);
        check("c_rx_data", {56'd0, bus1.dataOut}, e.rx);
        check("c_mosi_stream", {56'd0, mosiCap1}, e.tx);
        check("c_sck_rises", rises1, 8);
      end
    end
    pSs1   = bus1.ssOut;
    pSck1  = bus1.sckOut;
    pBusy1 = bus1.busyOut;
  end

  task automatic waitUntil(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitIdle0(input int bound);
    int n = 0;
    while ((q0.size() != 0 || bus0.busyOut) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || bus0.busyOut) begin
      checks++;
      failures++;
      $display("FAIL timeout0: got %0d frames pending, required 0", q0.size());
      q0.delete();
    end
    @(negedge clk);
  endtask

  task automatic waitIdle1(input int bound);
    int n = 0;
    while ((q1.size() != 0 || bus1.busyOut) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (q1.size() != 0 || bus1.busyOut) begin
      checks++;
      failures++;
      $display("FAIL timeout1: got %0d frames pending, required 0", q1.size());
      q1.delete();
    end
    @(negedge clk);
  endtask

  task automatic pulseStart0();
    bus0.startIn = 1'b1;
    @(posedge clk);
    #1;
    bus0.startIn = 1'b0;
  endtask

  task automatic runFrame0(input vec_t v);
    int   s;
    exp_t e;
    pat0         = v.miso;
    dly0         = v.dly;
    bus0.dataIn  = v.tx;
    @(posedge clk);
    #1;
    s            = cyc;
    bus0.startIn = 1'b1;
    e = '{s + v.doneLat, s + 1, v.miso, v.tx};
    q0.push_back(e);
    @(negedge clk);
    check("busy_cycle0", {63'd0, bus0.busyOut}, 64'd0);
    @(posedge clk);
    #1;
    bus0.startIn = 1'b0;
    bus0.dataIn  = ~v.tx;
    @(negedge clk);
    check("ss_busy_cycle1", {62'd0, bus0.ssOut, bus0.busyOut}, 64'd1);
    waitIdle0(v.idleLat + 20);
    check("busy_fall_cycle", busyFall0, s + v.idleLat);
  endtask

  initial begin
    vec_t vecs[4];
    int   s;
    exp_t e;

    vecs[0] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 0, 1033, 1041};
    vecs[1] = '{64'h1234_5678_9ABC_DEF0, 64'hAAAA_5555_F0F0_0F0F, 5, 1033, 1041};
    vecs[2] = '{64'hFFFF_0000_A5A5_5A5A, 64'h8000_0000_0000_0001, 0, 1033, 1041};
    vecs[3] = '{64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5, 1033, 1041};

    bus0.startIn = 1'b0;
    bus0.dataIn  = '0;
    bus1.startIn = 1'b0;
    bus1.dataIn  = '0;

    // Reset with random start activity: outputs must sit at their idle values.
    repeat (12) begin
      bus0.startIn = 1'($urandom_range(0, 1));
      bus1.startIn = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("reset_pins0", {59'd0, bus0.ssOut, bus0.sckOut, bus0.busyOut, bus0.doneOut,
                            bus0.mosiOut}, 64'h10);
      check("reset_data0", bus0.dataOut, 64'd0);
      check("reset_pins1", {60'd0, bus1.ssOut, bus1.sckOut, bus1.busyOut, bus1.doneOut},
            64'h8);
    end
    bus0.startIn = 1'b0;
    bus1.startIn = 1'b0;
    @(posedge clk);
    #1;
    nResetIn = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single frames from the vector table, including late MISO.
    for (int i = 0; i < 4; i++) runFrame0(vecs[i]);

    // Level-held start: frames at 0, 1041, 2082.
    pat0 = 64'hC3C3_3C3C_0102_0408;
    dly0 = 0;
    bus0.dataIn = 64'h5A5A_A5A5_1357_9BDF;
    @(posedge clk);
    #1;
    s = cyc;
    bus0.startIn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e = '{s + k * 1041 + 1033, s + k * 1041 + 1, pat0, bus0.dataIn};
      q0.push_back(e);
    end
    repeat (3000) @(posedge clk);
    #1;
    bus0.startIn = 1'b0;
    waitIdle0(3000);

    // Start pulses while busy, on done, and in the last gap cycle are all ignored.
    vecs[0].tx = 64'h0F1E_2D3C_4B5A_6978;
    pat0 = 64'h8765_4321_0FED_CBA9;
    bus0.dataIn = vecs[0].tx;
    @(posedge clk);
    #1;
    s = cyc;
    e = '{s + 1033, s + 1, pat0, vecs[0].tx};
    q0.push_back(e);
    pulseStart0();
    waitUntil(s + 300);
    pulseStart0();
    waitUntil(s + 1033);
    pulseStart0();
    waitUntil(s + 1040);
    pulseStart0();
    waitIdle0(1200);
    repeat (50) @(negedge clk);
    checkTrue("no_extra_frame", !bus0.busyOut && q0.size() == 0, int'(bus0.busyOut));

    // Abort mid-frame with reset, then a clean frame.
    pat0 = 64'h1111_2222_3333_4444;
    bus0.dataIn = 64'h9999_8888_7777_6666;
    @(posedge clk);
    #1;
    s = cyc;
    e = '{s + 1033, s + 1, pat0, bus0.dataIn};
    q0.push_back(e);
    pulseStart0();
    waitUntil(s + 500);
    nResetIn = 1'b0;
    #1;
    check("abort_pins", {60'd0, bus0.ssOut, bus0.sckOut, bus0.busyOut, bus0.doneOut},
          64'h8);
    check("abort_data", bus0.dataOut, 64'd0);
    q0.delete();
    repeat (4) begin
      @(negedge clk);
      check("abort_hold", {61'd0, bus0.ssOut, bus0.sckOut, bus0.doneOut}, 64'h4);
    end
    @(posedge clk);
    #1;
    nResetIn = 1'b1;
    ssRise0 = -1;
    runFrame0(vecs[1]);

    // Corner instance: one byte, HALF_PERIOD=2, unit setup/hold/gap.
    pat1 = 8'h7E;
    bus1.dataIn = 8'h81;
    @(posedge clk);
    #1;
    s = cyc;
    bus1.startIn = 1'b1;
    e = '{s + 35, s + 1, 64'h7E, 64'h81};
    q1.push_back(e);
    @(posedge clk);
    #1;
    bus1.startIn = 1'b0;
    bus1.dataIn = 8'h00;
    waitIdle1(200);
    check("c_busy_fall_cycle", busyFall1, s + 36);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got no completion by cycle %0d, required finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
